noc_vc_grant_arbiter: RTL and testbench
=======================================

// Module: noc_vc_grant_arbiter
// PURPOSE
// - Generates the one-hot vc_grant that steers the VC merge stage: chooses which virtual channel
//   may push flits into the shared merge FIFO.
// - Round-robin arbitration with wormhole locking: a granted VC keeps the grant until its tail flit is accepted.
// - Sits beside the VC merge; observes per-VC valid/ready/tail at the merge input and drives its grant.
// PARAMETERS
// - CHANNELS   default Noc_VC_Channel  number of virtual channels (>=2)
// - WEIGHT_W   default 4               per-VC weight width (used only with NOC_VC_ARB_WEIGHT_EN)
// PORTS
// - noc_clk      in   1         router clock
// - noc_rst      in   1         asynchronous, active-high reset
// - i_vc_valid   in   CHANNELS  per-VC flit-valid at merge input (ungated)
// - i_vc_ready   in   CHANNELS  per-VC ready returned by merge (meaningful only on the granted VC)
// - i_vc_tail    in   CHANNELS  tail flag of the flit currently presented on each VC
// - o_vc_grant   out  CHANNELS  registered one-hot grant (all zero = none)
// - o_grant_idx  out  $clog2(CHANNELS)  binary index of granted VC; 0 when none
// - o_busy       out  1         state == LOCK
// - i_vc_weight  in   CHANNELS*WEIGHT_W  packets per turn per VC (only with NOC_VC_ARB_WEIGHT_EN)
// BEHAVIOUR
// - Reset: o_vc_grant=0, o_grant_idx=0, o_busy=0, rr pointer=0 (VC0 highest priority), state=IDLE.
// - beat = |(o_vc_grant & i_vc_valid & i_vc_ready); tail_beat = beat & |(o_vc_grant & i_vc_tail).
// - FSM: IDLE, LOCK.
//   - IDLE: any i_vc_valid -> pick first requester at or after ptr (wrap CHANNELS-1 -> 0); register grant; go LOCK.
//     Grant is visible one cycle after the request (latency 1). No request -> stay IDLE, grant 0.
//   - LOCK: grant held constant through any number of non-tail beats and stalls (valid or ready low).
//   - LOCK + tail_beat: ptr <= winner+1 (mod CHANNELS); same cycle, re-pick from current i_vc_valid
//     excluding the finishing VC unless it is the only requester. Winner -> stay LOCK with new grant
//     (zero-bubble back-to-back packets). No other requester and finishing VC idle -> IDLE, grant 0.
//   - Single-flit packet (head=tail): granted, released on its only beat.
// - Grant never changes except on tail_beat or reset; at most one grant bit set at any time.
// - Grant never goes to a VC whose i_vc_valid is low at pick time.
// - Reset asserted mid-packet: grant drops asynchronously; the partial packet is abandoned.
//   Upstream flushing is the router's responsibility.
// CONFIGURATION
// - NOC_VC_ARB_WEIGHT_EN defined: weighted round robin.
//   - On each new grant, credit counter <= i_vc_weight[winner]; a weight of 0 is treated as 1.
//   - Each tail_beat decrements credit.
//   - Credit still >0 after the decrement and the same VC is still valid: grant is kept and ptr is not advanced.
//   - Otherwise normal rotation.
// - Not defined: i_vc_weight port absent, no credit counter; each VC gets exactly one packet per turn.
// STRUCTURE
// - Noc_parameters package: Noc_VC_Channel, typedef enum logic {ARB_IDLE, ARB_LOCK} noc_vc_arb_state_e,
//   localparam NOC_VC_ARB_WEIGHT_W = 4.
// - Sub-module noc_rr_pick (combinational):
//   - Inputs: req[CHANNELS], ptr, mask.
//   - Outputs: one-hot gnt, idx, any.
//   - Implemented as a double-width rotate plus priority encoder.
// - Top holds the FSM, ptr, grant and credit registers only.
// TESTING
// - Reset, then i_vc_valid=4'b1010: grant=4'b0010 one cycle later, o_busy=1.
// - VC1 3-flit packet with ready toggling 1,0,1,1: grant stable until 3rd beat (tail), then rotates to VC3 with no idle cycle.
// - All four VCs continuously valid, 1-flit packets: grant sequence 0,1,2,3,0,1.
//   Each VC gets exactly 25% of beats over 400 cycles.
// - Only VC2 valid, back-to-back packets: VC2 re-granted after each tail.
//   o_busy stays 1; no other grant bit ever set.
// - Reset pulsed in the middle of a 5-flit VC0 packet: grant=0 immediately.
//   After release, ptr=0 and arbitration restarts from VC0.
// - With NOC_VC_ARB_WEIGHT_EN, weights {1,3,0,2}, all valid, 1-flit packets: order 0,1,1,1,2,3,3,0...

Source files
------------

// File: rtl/noc_vc_grant_arbiter_pkg.sv
// Shared NoC parameters and types for the VC grant arbiter.
// Optional build macro: NOC_VC_ARB_WEIGHT_EN (weighted round robin).
package Noc_parameters;

    localparam int Noc_VC_Channel      = 4;
    localparam int NOC_VC_ARB_WEIGHT_W = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } noc_vc_arb_state_e;

endpackage

// File: rtl/noc_vc_grant_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr,
// wrapping from CHANNELS-1 back to 0. Built as a double-width rotate followed
// by a priority encoder on the rotated vector.
module noc_rr_pick #(
    parameter int CHANNELS = 4,
    localparam int IDX_W = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    input  logic [CHANNELS-1:0] mask,
    output logic [CHANNELS-1:0] gnt,
    output logic [IDX_W-1:0]    idx,
    output logic                any
);

    logic [CHANNELS-1:0]   eligible;
    logic [2*CHANNELS-1:0] doubled;
    logic [CHANNELS-1:0]   rotated;
    logic [IDX_W-1:0]      offset;
    logic                  found;
    logic [IDX_W:0]        sum;

    assign eligible = req & ~mask;
    assign doubled  = {eligible, eligible};
    // Bit 0 of the rotated vector corresponds to the VC at ptr.
    assign rotated  = CHANNELS'(doubled >> ptr);
    assign any      = |eligible;

    // Priority-encode the rotated vector, then map the offset back to a VC index.
    always_comb begin
        offset = '0;
        found  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && rotated[i]) begin
                offset = i[IDX_W-1:0];
                found  = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (IDX_W+1)'(CHANNELS)) begin
            idx = IDX_W'(sum - (IDX_W+1)'(CHANNELS));
        end else begin
            idx = sum[IDX_W-1:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_onehot
            assign gnt[gi] = any && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/noc_vc_grant_arbiter.sv
// VC grant arbiter for the merge stage: round robin with wormhole locking.
// A granted VC keeps the grant until its tail flit is accepted; on that tail
// beat the next owner is picked in the same cycle so packets run back to back.
// Optional build macro: NOC_VC_ARB_WEIGHT_EN adds per-VC packet credits
// (weighted round robin) and the i_vc_weight port.
module noc_vc_grant_arbiter
    import Noc_parameters::*;
#(
    parameter int CHANNELS = Noc_VC_Channel
`ifdef NOC_VC_ARB_WEIGHT_EN
    ,
    parameter int WEIGHT_W = NOC_VC_ARB_WEIGHT_W
`endif
    ,
    localparam int IDX_W = $clog2(CHANNELS)
) (
    input  logic                noc_clk,
    input  logic                noc_rst,
    input  logic [CHANNELS-1:0] i_vc_valid,
    input  logic [CHANNELS-1:0] i_vc_ready,
    input  logic [CHANNELS-1:0] i_vc_tail,
    output logic [CHANNELS-1:0] o_vc_grant,
    output logic [IDX_W-1:0]    o_grant_idx,
    output logic                o_busy
`ifdef NOC_VC_ARB_WEIGHT_EN
    ,
    input  logic [CHANNELS*WEIGHT_W-1:0] i_vc_weight
`endif
);

    noc_vc_arb_state_e   state_reg;
    logic [CHANNELS-1:0] grant_reg;
    logic [IDX_W-1:0]    grant_idx_reg;
    logic [IDX_W-1:0]    ptr_reg;
    logic                busy_reg;

    logic                beat;
    logic                tail_beat;
    logic                winner_valid;
    logic [IDX_W-1:0]    ptr_after;
    logic [IDX_W-1:0]    pick_ptr;
    logic [CHANNELS-1:0] pick_mask;
    logic [CHANNELS-1:0] pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

    assign beat         = |(grant_reg & i_vc_valid & i_vc_ready);
    assign tail_beat    = beat & |(grant_reg & i_vc_tail);
    assign winner_valid = |(grant_reg & i_vc_valid);
    assign ptr_after    = (grant_idx_reg == IDX_W'(CHANNELS - 1)) ? '0 : grant_idx_reg + 1'b1;

    // When idle, search from the stored pointer; when finishing a packet,
    // search from just past the winner and skip the finishing VC.
    assign pick_ptr  = (state_reg == ARB_LOCK) ? ptr_after : ptr_reg;
    assign pick_mask = (state_reg == ARB_LOCK) ? grant_reg : '0;

    noc_rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_pick (
        .req  (i_vc_valid),
        .ptr  (pick_ptr),
        .mask (pick_mask),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

`ifdef NOC_VC_ARB_WEIGHT_EN
    logic [WEIGHT_W-1:0] weight_arr [CHANNELS];
    logic [WEIGHT_W-1:0] credit_reg;
    logic [WEIGHT_W-1:0] credit_left;
    logic [WEIGHT_W-1:0] pick_credit;
    logic [WEIGHT_W-1:0] same_credit;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_weight
            assign weight_arr[gi] = i_vc_weight[gi*WEIGHT_W +: WEIGHT_W];
        end
    endgenerate

    // A zero weight still earns one packet per turn.
    assign credit_left = credit_reg - 1'b1;
    assign pick_credit = (weight_arr[pick_idx] == '0) ? WEIGHT_W'(1) : weight_arr[pick_idx];
    assign same_credit = (weight_arr[grant_idx_reg] == '0) ? WEIGHT_W'(1) : weight_arr[grant_idx_reg];
`endif

    // Arbitration FSM: grant, index, pointer, busy (and credit) registers.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state_reg     <= ARB_IDLE;
            grant_reg     <= '0;
            grant_idx_reg <= '0;
            ptr_reg       <= '0;
            busy_reg      <= 1'b0;
`ifdef NOC_VC_ARB_WEIGHT_EN
            credit_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state_reg     <= ARB_LOCK;
                        busy_reg      <= 1'b1;
                        grant_reg     <= pick_gnt;
                        grant_idx_reg <= pick_idx;
`ifdef NOC_VC_ARB_WEIGHT_EN
                        credit_reg    <= pick_credit;
`endif
                    end
                end
                ARB_LOCK: begin
                    if (tail_beat) begin
`ifdef NOC_VC_ARB_WEIGHT_EN
                        if ((credit_left != '0) && winner_valid) begin
                            // Credit remains: same VC keeps the turn, pointer stays.
                            credit_reg <= credit_left;
                        end else
`endif
                        begin
                            ptr_reg <= ptr_after;
                            if (pick_any) begin
                                grant_reg     <= pick_gnt;
                                grant_idx_reg <= pick_idx;
`ifdef NOC_VC_ARB_WEIGHT_EN
                                credit_reg    <= pick_credit;
`endif
                            end else if (winner_valid) begin
                                // Sole requester is the finishing VC: re-grant it.
`ifdef NOC_VC_ARB_WEIGHT_EN
                                credit_reg    <= same_credit;
`endif
                            end else begin
                                state_reg     <= ARB_IDLE;
                                busy_reg      <= 1'b0;
                                grant_reg     <= '0;
                                grant_idx_reg <= '0;
                            end
                        end
                    end
                end
                default: begin
                    state_reg     <= ARB_IDLE;
                    busy_reg      <= 1'b0;
                    grant_reg     <= '0;
                    grant_idx_reg <= '0;
                end
            endcase
        end
    end

    assign o_vc_grant  = grant_reg;
    assign o_grant_idx = grant_idx_reg;
    assign o_busy      = busy_reg;

endmodule

// File: tb/tb_noc_vc_grant_arbiter.sv
// Directed bench for noc_vc_grant_arbiter (4 VCs). Inputs change and outputs
// are sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_noc_vc_grant_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] vc_valid;
    logic [3:0] vc_ready;
    logic [3:0] vc_tail;
    logic [3:0] vc_grant;
    logic [1:0] grant_idx;
    logic       busy;
`ifdef NOC_VC_ARB_WEIGHT_EN
    logic [15:0] vc_weight;
`endif

    int errors = 0;
    int checks = 0;

    noc_vc_grant_arbiter #(
        .CHANNELS (4)
    ) dut (
        .noc_clk     (clk),
        .noc_rst     (rst),
        .i_vc_valid  (vc_valid),
        .i_vc_ready  (vc_ready),
        .i_vc_tail   (vc_tail),
        .o_vc_grant  (vc_grant),
        .o_grant_idx (grant_idx),
        .o_busy      (busy)
`ifdef NOC_VC_ARB_WEIGHT_EN
        ,
        .i_vc_weight (vc_weight)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        rst      = 1'b1;
        vc_valid = 4'b0000;
        vc_ready = 4'b0000;
        vc_tail  = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        vc_valid = 4'b1111;
        vc_ready = 4'b1111;
        vc_tail  = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (vc_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", vc_grant); end
        checks++;
        if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", grant_idx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        $display("test_reset: grant=%b idx=%0d busy=%b", vc_grant, grant_idx, busy);
    endtask

    task automatic test_first_grant_and_wormhole();
        logic [3:0] ready_seq [4];
        logic [3:0] tail_seq  [4];
        logic [3:0] exp_seq   [4];
        do_reset();
        vc_valid = 4'b1010;
        #1;
        checks++;
        if (vc_grant !== 4'b0000) begin errors++; $display("FAIL latency_zero: got %b want 0000", vc_grant); end
        @(negedge clk);
        checks++;
        if (vc_grant !== 4'b0010) begin errors++; $display("FAIL first_grant: got %b want 0010", vc_grant); end
        checks++;
        if (grant_idx !== 2'd1) begin errors++; $display("FAIL first_idx: got %0d want 1", grant_idx); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b want 1", busy); end
        $display("first_grant: grant=%b idx=%0d busy=%b", vc_grant, grant_idx, busy);
        // VC1 3-flit packet, ready 1,0,1,1; tail on the last beat.
        ready_seq = '{4'b1111, 4'b0000, 4'b1111, 4'b1111};
        tail_seq  = '{4'b0000, 4'b0000, 4'b0000, 4'b0010};
        exp_seq   = '{4'b0010, 4'b0010, 4'b0010, 4'b1000};
        for (int k = 0; k < 4; k++) begin
            vc_ready = ready_seq[k];
            vc_tail  = tail_seq[k];
            @(negedge clk);
            checks++;
            if (vc_grant !== exp_seq[k]) begin
                errors++;
                $display("FAIL wormhole_grant[%0d]: got %b want %b", k, vc_grant, exp_seq[k]);
            end
            $display("wormhole cycle %0d: ready=%b tail=%b grant=%b", k, ready_seq[k], tail_seq[k], vc_grant);
        end
        checks++;
        if (grant_idx !== 2'd3) begin errors++; $display("FAIL wormhole_idx: got %0d want 3", grant_idx); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL wormhole_busy: got %b want 1", busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [6];
        int cnt [4];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        do_reset();
        vc_valid = 4'b1111;
        vc_ready = 4'b1111;
        vc_tail  = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (vc_grant !== exp_seq[k]) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got %b want %b", k, vc_grant, exp_seq[k]);
            end
            $display("round_robin %0d: grant=%b", k, vc_grant);
        end
        for (int v = 0; v < 4; v++) cnt[v] = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            case (vc_grant)
                4'b0001: cnt[0]++;
                4'b0010: cnt[1]++;
                4'b0100: cnt[2]++;
                4'b1000: cnt[3]++;
                default: ;
            endcase
        end
        for (int v = 0; v < 4; v++) begin
            checks++;
            if (cnt[v] !== 100) begin
                errors++;
                $display("FAIL rr_share[%0d]: got %0d beats want 100", v, cnt[v]);
            end
            $display("fairness VC%0d: %0d of 400 beats", v, cnt[v]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        vc_valid = 4'b0100;
        vc_ready = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            vc_tail = (k % 2 == 1) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            checks++;
            if (vc_grant !== 4'b0100 || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: got grant=%b busy=%b want grant=0100 busy=1", k, vc_grant, busy);
            end
            $display("back_to_back %0d: tail=%b grant=%b busy=%b", k, vc_tail, vc_grant, busy);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
        do_reset();
        vc_valid = 4'b0011;
        vc_ready = 4'b1111;
        vc_tail  = 4'b0011;
        // VC0, VC1 single flits move the pointer to 2, then VC0 starts a long packet.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) vc_tail = 4'b0000;
            checks++;
            if (vc_grant !== exp_seq[k]) begin
                errors++;
                $display("FAIL midrst_pre[%0d]: got %b want %b", k, vc_grant, exp_seq[k]);
            end
            $display("mid_packet %0d: grant=%b", k, vc_grant);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (vc_grant !== 4'b0000 || busy !== 1'b0 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got grant=%b busy=%b idx=%0d want 0000/0/0", vc_grant, busy, grant_idx);
        end
        $display("async reset: grant=%b busy=%b", vc_grant, busy);
        @(negedge clk);
        rst      = 1'b0;
        vc_valid = 4'b0101;
        vc_tail  = 4'b0000;
        @(negedge clk);
        checks++;
        if (vc_grant !== 4'b0001 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL restart_vc0: got grant=%b idx=%0d want 0001/0", vc_grant, grant_idx);
        end
        $display("restart after reset: grant=%b idx=%0d", vc_grant, grant_idx);
    endtask

`ifdef NOC_VC_ARB_WEIGHT_EN
    task automatic test_weighted();
        logic [1:0] exp_seq [8];
        exp_seq = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
        vc_weight = 16'h2031;
        do_reset();
        vc_valid = 4'b1111;
        vc_ready = 4'b1111;
        vc_tail  = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (grant_idx !== exp_seq[k]) begin
                errors++;
                $display("FAIL wrr_seq[%0d]: got %0d want %0d", k, grant_idx, exp_seq[k]);
            end
            $display("weighted %0d: idx=%0d", k, grant_idx);
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        vc_valid = 4'b0000;
        vc_ready = 4'b0000;
        vc_tail  = 4'b0000;
`ifdef NOC_VC_ARB_WEIGHT_EN
        vc_weight = 16'h1111;
`endif
        test_reset();
        test_first_grant_and_wormhole();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_packet();
`ifdef NOC_VC_ARB_WEIGHT_EN
        test_weighted();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
